pipeline_stall_controller: RTL and testbench

//  Central stall/flush sequencer for the 5-stage ARM pipeline. Combines the ID

---
 rtl/pipeline_stall_controller.sv | 174 +++++++++++++++++
 tb/tb_pipeline_stall_controller.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Turns the ID hazard flag, the EXE branch-taken flag and a fixed-latency
// MEM-stage access into per-stage freeze/flush controls, and counts stall
// cycles and branch flushes with saturating counters.
//
// The memory side is a two-state FSM (RUN / WAIT). An access seen in RUN
// freezes the whole pipeline for MEM_LATENCY-1 cycles. mem_ready is raised in
// the cycle after the last frozen cycle. Dropping the request in WAIT aborts
// the access without a mem_ready pulse.
//
// Handshake: mem_r_en/mem_w_en act as a level request that must stay high
// until mem_ready. mem_ready is a single-cycle completion strobe. A request
// that is still high in the cycle after mem_ready belongs to the next
// instruction and starts a new access immediately.
module pipeline_stall_controller #(
    parameter int MEM_LATENCY = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_Detected,
    input  logic             branch_taken,
    input  logic             mem_r_en,
    input  logic             mem_w_en,
    output logic             freeze_PC,
    output logic             freeze_IF_ID,
    output logic             flush_IF_ID,
    output logic             flush_ID_EXE,
    output logic             freeze_all,
    output logic             mem_ready,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             dbg_state
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // Value loaded into the wait counter on entering WAIT. It is clamped so
    // that MEM_LATENCY==1 still elaborates, even though WAIT is never
    // entered in that case.
    localparam int WAIT_INIT = (MEM_LATENCY > 1) ? MEM_LATENCY - 2 : 0;
    localparam int WCNT_W    = (WAIT_INIT > 1) ? $clog2(WAIT_INIT + 1) : 1;

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]    flush_cnt_q, flush_cnt_d;
    logic                req;
    logic                mem_freeze;
    logic                mem_done;

    assign req = mem_r_en | mem_w_en;

    // State register: FSM state and remaining wait cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next-state logic: enter WAIT on a multi-cycle access, count down, and
    // leave on completion or when the request disappears.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_RUN: begin
                if (req && (MEM_LATENCY > 1)) begin
                    state_d = ST_WAIT;
                    wcnt_d  = WCNT_W'(WAIT_INIT);
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    state_d = ST_RUN;
                end else if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // FSM outputs: freeze while the access is in progress, strobe on completion.
    always_comb begin
        mem_freeze = 1'b0;
        mem_done   = 1'b0;
        if (!rst && req) begin
            case (state_q)
                ST_RUN: begin
                    if (MEM_LATENCY > 1) begin
                        mem_freeze = 1'b1;
                    end else begin
                        mem_done = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (wcnt_q != '0) begin
                        mem_freeze = 1'b1;
                    end else begin
                        mem_done = 1'b1;
                    end
                end
                default: begin
                    mem_freeze = 1'b0;
                end
            endcase
        end
    end

    // Pipeline controls in priority order: memory freeze, branch flush,
    // then the hazard stall. Branch and hazard flags are ignored while the
    // pipe is frozen, because they stay asserted and are served afterwards.
    always_comb begin
        freeze_PC    = 1'b0;
        freeze_IF_ID = 1'b0;
        flush_IF_ID  = 1'b0;
        flush_ID_EXE = 1'b0;
        if (rst) begin
            freeze_PC = 1'b0;
        end else if (mem_freeze) begin
            freeze_PC    = 1'b1;
            freeze_IF_ID = 1'b1;
        end else if (branch_taken) begin
            flush_IF_ID  = 1'b1;
            flush_ID_EXE = 1'b1;
        end else if (hazard_Detected) begin
            freeze_PC    = 1'b1;
            freeze_IF_ID = 1'b1;
            flush_ID_EXE = 1'b1;
        end
    end

    // Saturating event counters: increment, but hold at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (freeze_PC && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush_IF_ID && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign freeze_all = mem_freeze;
    assign mem_ready  = mem_done;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Testbench for pipeline_stall_controller.
// Two instances share one input stream: A (latency 4, 16-bit counters) and
// B (latency 1, 2-bit counters, which saturate quickly). The driver pushes
// per-cycle expectations from an access-age model. A negedge monitor pops
// these expectations and compares them with the DUT outputs.
module tb_pipeline_stall_controller;

  localparam int LAT_A = 4;
  localparam int CW_A  = 16;
  localparam int LAT_B = 1;
  localparam int CW_B  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, hazard_Detected, branch_taken, mem_r_en, mem_w_en;

  logic            a_fpc, a_fif, a_flif, a_flid, a_fa, a_mr, a_dbg;
  logic [CW_A-1:0] a_scnt, a_fcnt;
  logic            b_fpc, b_fif, b_flif, b_flid, b_fa, b_mr, b_dbg;
  logic [CW_B-1:0] b_scnt, b_fcnt;

  pipeline_stall_controller #(.MEM_LATENCY(LAT_A), .CNT_W(CW_A)) dut_a (
    .clk(clk), .rst(rst), .hazard_Detected(hazard_Detected),
    .branch_taken(branch_taken), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .freeze_PC(a_fpc), .freeze_IF_ID(a_fif), .flush_IF_ID(a_flif),
    .flush_ID_EXE(a_flid), .freeze_all(a_fa), .mem_ready(a_mr),
    .stall_cnt(a_scnt), .flush_cnt(a_fcnt), .dbg_state(a_dbg)
  );

  pipeline_stall_controller #(.MEM_LATENCY(LAT_B), .CNT_W(CW_B)) dut_b (
    .clk(clk), .rst(rst), .hazard_Detected(hazard_Detected),
    .branch_taken(branch_taken), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .freeze_PC(b_fpc), .freeze_IF_ID(b_fif), .flush_IF_ID(b_flif),
    .flush_ID_EXE(b_flid), .freeze_all(b_fa), .mem_ready(b_mr),
    .stall_cnt(b_scnt), .flush_cnt(b_fcnt), .dbg_state(b_dbg)
  );

  // ---------------- scoreboard state ----------------
  // Expected vector: {in_wait, freeze_PC, freeze_IF_ID, flush_IF_ID,
  //                   flush_ID_EXE, freeze_all, mem_ready, stall_cnt, flush_cnt}
  logic [7+2*CW_A-1:0] exp_a_q[$];
  logic [7+2*CW_B-1:0] exp_b_q[$];

  int checks = 0;
  int passes = 0;
  int cycle  = 0;

  // Reference model: age = cycles the current access has already spent in MEM.
  int age_a = 0, age_b = 0;
  int scnt_a = 0, fcnt_a = 0, scnt_b = 0, fcnt_b = 0;

  function automatic logic [6:0] model_bits(input int lat, input int age,
                                            input logic r, input logic h,
                                            input logic b, input logic q);
    logic w, fpc, fif, flif, flid, fa, mr;
    w = (age > 0);
    fpc = 0; fif = 0; flif = 0; flid = 0; fa = 0; mr = 0;
    if (!r) begin
      if (q) begin
        if (age == lat - 1) mr = 1;
        else                fa = 1;
      end
      if (fa) begin
        fpc = 1; fif = 1;
      end else if (b) begin
        flif = 1; flid = 1;
      end else if (h) begin
        fpc = 1; fif = 1; flid = 1;
      end
    end
    return {w, fpc, fif, flif, flid, fa, mr};
  endfunction

  function automatic int next_age(input int lat, input int age,
                                  input logic r, input logic q);
    if (r || !q)          return 0;
    if (age == lat - 1)   return 0;
    return age + 1;
  endfunction

  function automatic int sat_inc(input int v, input int maxv, input logic en);
    if (en && v < maxv) return v + 1;
    return v;
  endfunction

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic r, input logic h, input logic b,
                             input logic rd, input logic wr);
    logic [6:0] ba, bb;
    logic q;
    @(posedge clk);
    #1;
    rst = r; hazard_Detected = h; branch_taken = b; mem_r_en = rd; mem_w_en = wr;
    q  = rd | wr;
    ba = model_bits(LAT_A, age_a, r, h, b, q);
    bb = model_bits(LAT_B, age_b, r, h, b, q);
    exp_a_q.push_back({ba, scnt_a[CW_A-1:0], fcnt_a[CW_A-1:0]});
    exp_b_q.push_back({bb, scnt_b[CW_B-1:0], fcnt_b[CW_B-1:0]});
    if (r) begin
      scnt_a = 0; fcnt_a = 0; scnt_b = 0; fcnt_b = 0;
    end else begin
      scnt_a = sat_inc(scnt_a, (1 << CW_A) - 1, ba[5]);
      fcnt_a = sat_inc(fcnt_a, (1 << CW_A) - 1, ba[3]);
      scnt_b = sat_inc(scnt_b, (1 << CW_B) - 1, bb[5]);
      fcnt_b = sat_inc(fcnt_b, (1 << CW_B) - 1, bb[3]);
    end
    age_a = next_age(LAT_A, age_a, r, q);
    age_b = next_age(LAT_B, age_b, r, q);
    cycle++;
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- monitor ----------------
  // Compare every cycle that has an expectation against the sampled outputs.
  always @(negedge clk) begin
    logic [7+2*CW_A-1:0] ea, aa;
    logic [7+2*CW_B-1:0] eb, ab;
    if (exp_a_q.size() > 0) begin
      ea = exp_a_q.pop_front();
      aa = {a_dbg, a_fpc, a_fif, a_flif, a_flid, a_fa, a_mr, a_scnt, a_fcnt};
      checks++;
      if (aa === ea) passes++;
      else $display("FAIL dut_a cycle %0d: got %h expected %h", cycle, aa, ea);
    end
    if (exp_b_q.size() > 0) begin
      eb = exp_b_q.pop_front();
      ab = {b_dbg, b_fpc, b_fif, b_flif, b_flid, b_fa, b_mr, b_scnt, b_fcnt};
      checks++;
      if (ab === eb) passes++;
      else $display("FAIL dut_b cycle %0d: got %h expected %h", cycle, ab, eb);
    end
  end

  // ---------------- stimulus ----------------
  logic req_on = 1'b0;
  logic rd_sel, wr_sel;
  int   run_left = 0;

  initial begin
    rst = 1; hazard_Detected = 1; branch_taken = 1; mem_r_en = 1; mem_w_en = 1;
    @(posedge clk);
    @(posedge clk);

    // Reset held with every input high: outputs low, counters zero.
    repeat (3) drive_cycle(1, 1, 1, 1, 1);
    repeat (3) drive_cycle(0, 0, 0, 0, 0);

    // Read held across a full access: three freeze cycles, then mem_ready.
    repeat (4) drive_cycle(0, 0, 0, 1, 0);
    drive_cycle(0, 0, 0, 0, 0);
    @(negedge clk);
    check_val("read_access_stall_cnt", int'(a_scnt), 3);

    // Two hazard cycles with no memory request.
    repeat (2) drive_cycle(0, 1, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 0);
    @(negedge clk);
    check_val("hazard_stall_cnt", int'(a_scnt), 5);

    // Branch and hazard in the same cycle: the branch wins.
    drive_cycle(0, 1, 1, 0, 0);
    drive_cycle(0, 0, 0, 0, 0);
    @(negedge clk);
    check_val("branch_flush_cnt", int'(a_fcnt), 1);
    check_val("branch_no_stall", int'(a_scnt), 5);

    // Branch held across a write access: it flushes only once the freeze drops.
    repeat (4) drive_cycle(0, 0, 1, 0, 1);
    drive_cycle(0, 0, 1, 0, 0);
    drive_cycle(0, 0, 0, 0, 0);
    @(negedge clk);
    check_val("wait_branch_stall_cnt", int'(a_scnt), 8);
    check_val("wait_branch_flush_cnt", int'(a_fcnt), 3);

    // Back-to-back accesses with no idle gap.
    repeat (8) drive_cycle(0, 0, 0, 1, 1);
    drive_cycle(0, 0, 0, 0, 0);

    // Reset in the second WAIT cycle aborts the access.
    drive_cycle(0, 0, 0, 1, 0);
    drive_cycle(0, 0, 0, 1, 0);
    drive_cycle(1, 0, 0, 1, 0);
    repeat (2) drive_cycle(0, 0, 0, 0, 0);
    @(negedge clk);
    check_val("abort_freeze_all", int'(a_fa), 0);
    check_val("abort_state", int'(a_dbg), 0);

    // Five stall cycles: the narrow counter saturates at 3.
    repeat (5) drive_cycle(0, 1, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 0);
    @(negedge clk);
    check_val("sat_stall_cnt_b", int'(b_scnt), 3);
    check_val("wide_stall_cnt_a", int'(a_scnt), 5);

    // Randomised traffic with request runs, aborts, hazards, branches and resets.
    for (int i = 0; i < 2000; i++) begin
      if (run_left == 0) begin
        req_on   = ~req_on;
        run_left = req_on ? $urandom_range(1, 9) : $urandom_range(1, 3);
        rd_sel   = 1'($urandom_range(0, 1));
        wr_sel   = rd_sel ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      run_left--;
      drive_cycle(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 4) == 0), req_on & rd_sel, req_on & wr_sel);
    end

    @(negedge clk);
    @(posedge clk);
    check_val("scoreboard_drained", exp_a_q.size() + exp_b_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
